// File: rtl/extend_pipe.sv
// extend_pipe: registered immediate extender feeding a two-entry skid buffer.
// Each accepted instr/imm_src pair is decoded into its extended immediate,
// sub-word selector, rotate carry-out and illegal flag, then queued so the
// execute stage can stall decode without dropping operands. Head outputs read
// as zero whenever the buffer is empty.
module extend_pipe #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [23:0]       instr,
    input  logic [2:0]        imm_src,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext_imm,
    output logic [1:0]        mem_sel,
    output logic              rot_carry,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] imm;
        logic [1:0]        sel;
        logic              carry;
        logic              ill;
    } ent_t;

    // Decode one instruction immediate according to its extend mode.
    function automatic ent_t f_extend(input logic [23:0] ins, input logic [2:0] src);
        ent_t              e;
        logic [4:0]        rot_amt;
        logic [63:0]       rot_dbl;
        logic [31:0]       rot_val;
        logic signed [25:0] br_off;
        logic signed [11:0] imm12;
        e       = '0;
        rot_amt = {ins[11:8], 1'b0};
        rot_dbl = {24'd0, ins[7:0], 24'd0, ins[7:0]} >> rot_amt;
        rot_val = rot_dbl[31:0];
        br_off  = $signed({ins, 2'b00});
        imm12   = $signed(ins[11:0]);
        case (src)
            3'b000: e.imm = {{(DATA_W-12){1'b0}}, ins[11:0]};
            3'b001: begin
                e.sel = ins[1:0];
                if (ins[1:0] == 2'b01 || ins[1:0] == 2'b10)
                    e.imm = {{(DATA_W-10){1'b0}}, ins[11:2]};
                else
                    e.imm = {{(DATA_W-12){1'b0}}, ins[11:0]};
            end
            3'b010: e.imm = {{(DATA_W-26){br_off[25]}}, br_off};
            3'b011: begin
                // Rotating by zero leaves the shifter carry untouched, so report 0.
                e.imm   = {{(DATA_W-32){1'b0}}, rot_val};
                e.carry = (rot_amt != 5'd0) && rot_val[31];
            end
            3'b100: e.imm = {{(DATA_W-12){imm12[11]}}, imm12};
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Saturating increment for the illegal-entry counter.
    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    ent_t             r_buf [2];
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_ill_cnt;

    logic             w_push;
    logic             w_pop;
    ent_t             w_new;
    ent_t             w_head;

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_new     = f_extend(instr, imm_src);

    // Pointer, occupancy and illegal-counter bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head    <= 1'b0;
            r_tail    <= 1'b0;
            r_count   <= 2'd0;
            r_ill_cnt <= '0;
        end else begin
            if (w_push)
                r_tail <= ~r_tail;
            if (w_pop)
                r_head <= ~r_head;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_new.ill)
                r_ill_cnt <= f_sat_inc(r_ill_cnt);
        end
    end

    // Entry storage; contents only matter while counted, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push)
            r_buf[r_tail] <= w_new;
    end

    // Present the head entry, forced to zero when the buffer is empty.
    always_comb begin
        w_head = '0;
        if (r_count != 2'd0)
            w_head = r_buf[r_head];
    end

    assign ext_imm     = w_head.imm;
    assign mem_sel     = w_head.sel;
    assign rot_carry   = w_head.carry;
    assign illegal     = w_head.ill;
    assign illegal_cnt = r_ill_cnt;

endmodule

// File: tb/tb_extend_pipe.sv
// tb_extend_pipe: directed-vector bench for extend_pipe (DATA_W=32, CNT_W=8).
module tb_extend_pipe;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [23:0]       instr;
    logic [2:0]        imm_src;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] ext_imm;
    logic [1:0]        mem_sel;
    logic              rot_carry;
    logic              illegal;
    logic [CNT_W-1:0]  illegal_cnt;

    int n_chk = 0;
    int n_err = 0;
    int exp_cnt = 0;

    extend_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .imm_src    (imm_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ext_imm    (ext_imm),
        .mem_sel    (mem_sel),
        .rot_carry  (rot_carry),
        .illegal    (illegal),
        .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Push one entry into an empty buffer, check the head one cycle later, then drain it.
    task automatic single(input string tag, input logic [2:0] src, input logic [23:0] ins,
                          input logic [31:0] e_imm, input logic [1:0] e_sel,
                          input logic e_car, input logic e_ill);
        imm_src   = src;
        instr     = ins;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({tag, ".pre_vld"}, out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (e_ill && exp_cnt < 255) exp_cnt++;
        chk({tag, ".vld"}, out_valid, 1);
        chk({tag, ".imm"}, ext_imm, e_imm);
        chk({tag, ".sel"}, mem_sel, e_sel);
        chk({tag, ".car"}, rot_carry, e_car);
        chk({tag, ".ill"}, illegal, e_ill);
        chk({tag, ".cnt"}, illegal_cnt, exp_cnt);
        @(posedge clk); #1;
        chk({tag, ".drain"}, out_valid, 0);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = '0;
        imm_src   = '0;
        #3;
        chk("rst.vld", out_valid, 0);
        chk("rst.rdy", in_ready, 1);
        chk("rst.imm", ext_imm, 0);
        chk("rst.ill", illegal, 0);
        chk("rst.cnt", illegal_cnt, 0);
        #9 reset = 1'b1;
        @(posedge clk); #1;

        // Extend modes
        single("rot8",  3'b011, 24'h0004FF, 32'hFF000000, 2'd0, 1'b1, 1'b0);
        single("rot0",  3'b011, 24'h0000FF, 32'h000000FF, 2'd0, 1'b0, 1'b0);
        single("rot2",  3'b011, 24'h0001FF, 32'hC000003F, 2'd0, 1'b1, 1'b0);
        single("mem1",  3'b001, 24'hFFF7F1, 32'h000001FC, 2'd1, 1'b0, 1'b0);
        single("mem3",  3'b001, 24'h0007F3, 32'h000007F3, 2'd3, 1'b0, 1'b0);
        single("mem2",  3'b001, 24'h0007F2, 32'h000001FC, 2'd2, 1'b0, 1'b0);
        single("brneg", 3'b010, 24'hFFFFFE, 32'hFFFFFFF8, 2'd0, 1'b0, 1'b0);
        single("brpos", 3'b010, 24'h000010, 32'h00000040, 2'd0, 1'b0, 1'b0);
        single("zext",  3'b000, 24'hABC823, 32'h00000823, 2'd0, 1'b0, 1'b0);
        single("sxneg", 3'b100, 24'h000800, 32'hFFFFF800, 2'd0, 1'b0, 1'b0);
        single("sxpos", 3'b100, 24'hFFF7FF, 32'h000007FF, 2'd0, 1'b0, 1'b0);
        single("ill5",  3'b101, 24'hFFFFFF, 32'h00000000, 2'd0, 1'b0, 1'b1);

        // Backpressure: A, B accepted, C held, then drained in order
        out_ready = 1'b0;
        imm_src   = 3'b000;
        instr     = 24'h00000A;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        chk("bp.A.vld", out_valid, 1);
        chk("bp.A.rdy", in_ready, 1);
        chk("bp.A.imm", ext_imm, 32'h00A);
        instr = 24'h00000B;
        @(posedge clk); #1;
        chk("bp.full.rdy", in_ready, 0);
        chk("bp.full.imm", ext_imm, 32'h00A);
        instr = 24'h00000C;
        @(posedge clk); #1;
        chk("bp.hold.rdy", in_ready, 0);
        chk("bp.hold.imm", ext_imm, 32'h00A);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.B.imm", ext_imm, 32'h00B);
        chk("bp.B.rdy", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.C.vld", out_valid, 1);
        chk("bp.C.imm", ext_imm, 32'h00C);
        @(posedge clk); #1;
        chk("bp.empty", out_valid, 0);

        // 300 illegal entries streamed back-to-back
        imm_src  = 3'b111;
        instr    = 24'h123456;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            if (exp_cnt < 255) exp_cnt++;
            chk("ill.vld", out_valid, 1);
            chk("ill.rdy", in_ready, 1);
            chk("ill.imm", ext_imm, 0);
            chk("ill.flag", illegal, 1);
            chk("ill.cnt", illegal_cnt, exp_cnt);
        end
        in_valid = 1'b0;
        chk("ill.sat", illegal_cnt, 255);
        @(posedge clk); #1;
        chk("ill.empty", out_valid, 0);

        // Reset asserted between edges with a full buffer
        out_ready = 1'b0;
        imm_src   = 3'b000;
        instr     = 24'h000111;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        instr = 24'h000222;
        @(posedge clk); #1;
        chk("mrst.full", in_ready, 0);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        exp_cnt = 0;
        chk("mrst.vld", out_valid, 0);
        chk("mrst.rdy", in_ready, 1);
        chk("mrst.imm", ext_imm, 0);
        chk("mrst.cnt", illegal_cnt, 0);
        #2 reset = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("mrst.nostale", out_valid, 0);
        single("mrst.new", 3'b000, 24'h000333, 32'h00000333, 2'd0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/extend_pipe.md
# extend_pipe

Parametrised, registered successor to the single-cycle immediate extender in the ARM-style datapath. It accepts a 24-bit instruction immediate field plus an extend mode over a valid/ready handshake and computes the extended immediate, the sub-word memory selector, the rotate carry-out and an illegal-mode flag. Results are held in a two-entry skid buffer so the decode stage can be stalled by the execute stage without losing operands. It sits between decode and the operand-select mux of execute.

## Interface
- DATA_W, 32: width of ext_imm; legal values 32 or 64.
- CNT_W, 8: width of the saturating illegal-mode counter.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream offers instr/imm_src this cycle.
- in_ready  out  1  buffer can accept; equals (count < 2).
- instr  in  24  instruction bits [23:0].
- imm_src  in  3  extend mode.
- out_valid  out  1  head entry valid; equals (count > 0).
- out_ready  in  1  downstream consumes the head entry.
- ext_imm  out  DATA_W  extended immediate of the head entry.
- mem_sel  out  2  sub-word selector of the head entry.
- rot_carry  out  1  shifter carry-out of the head entry.
- illegal  out  1  head entry came from an undefined imm_src.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal entries.

## Operation
- Compute on accept, from instr/imm_src; the result is stored in the buffer tail.
- imm_src 000: ext_imm = zero-extend instr[11:0]; mem_sel 0; rot_carry 0.
- imm_src 001 (memory): if instr[1:0] is 01 or 10, ext_imm = zero-extend instr[11:2], else zero-extend instr[11:0]; mem_sel = instr[1:0].
- imm_src 010 (branch): ext_imm = sign-extend {instr[23:0], 2'b00} to DATA_W; mem_sel 0.
- imm_src 011 (rotate): r = 2*instr[11:8]; v = 32-bit zero-extended instr[7:0] rotated right by r. ext_imm = v zero-extended to DATA_W. rot_carry = v[31] if r != 0, else 0.
- imm_src 100: ext_imm = sign-extend instr[11:0] to DATA_W; mem_sel 0.
- imm_src 101/110/111: ext_imm 0, mem_sel 0, rot_carry 0, illegal 1. illegal_cnt increments on accept and saturates at 2^CNT_W-1.
- The buffer is a 2-entry FIFO with head/tail pointers and count 0..2.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Order is strictly preserved; there is no combinational input-to-output bypass.
- Outputs ext_imm/mem_sel/rot_carry/illegal always reflect the head entry. When count = 0 they are 0.

## Timing
- Reset (asynchronous, while reset = 0): count 0, pointers 0, out_valid 0, in_ready 1, ext_imm 0, mem_sel 0, rot_carry 0, illegal 0, illegal_cnt 0. This takes effect immediately, including mid-operation; buffered entries are discarded.
- Latency: an entry accepted at edge N is visible with out_valid = 1 after edge N; minimum 1 cycle.
- Throughput: 1 entry per cycle with out_ready held high.
- count 0: push only; the cycle after, count is 1.
- count 1, push and pop together: count stays 1; the new entry becomes head after the edge.
- count 2: in_ready = 0 and no push is possible. Pop makes count 1, and in_ready = 1 in the next cycle.
- Pop with count 0 is impossible, since out_valid = 0.
- Downstream holds out_ready independently. Upstream must hold instr/imm_src stable while in_valid = 1 and in_ready = 0.
- illegal_cnt updates on the same edge as the illegal entry's push.

## Test plan
- Rotate: imm_src 011, instr[11:0] = 0x4FF -> ext_imm 0xFF000000, rot_carry 1. For instr[11:0] = 0x0FF -> ext_imm 0x000000FF, rot_carry 0.
- Memory: imm_src 001, instr[11:0] = 0x7F1 -> ext_imm 0x1FC, mem_sel 01. For 0x7F3 -> ext_imm 0x7F3, mem_sel 11.
- Branch: imm_src 010, instr = 0xFFFFFE -> ext_imm 0xFFFFFFF8 (DATA_W=32) or 0xFFFFFFFFFFFFFFF8 (DATA_W=64). For instr = 0x000010 -> 0x40.
- Backpressure: out_ready 0, offer A, B, C on consecutive cycles -> A and B are accepted and in_ready is 0 after the second accept; C is held. Then out_ready 1 -> outputs A, B, C in order, one per cycle, with no loss or duplication.
- Illegal: 300 accepted entries with imm_src 111 -> each head shows ext_imm 0 and illegal 1. illegal_cnt stops at 255 (CNT_W=8).
- Reset mid-stream: count 2, reset pulled low between edges -> out_valid 0 and in_ready 1 immediately. After release, the first new accept appears one cycle later and no stale data is output.
